// File: rtl/port_request_sequencer.sv
// Captures one compacted three-lane request bundle, issues its lanes one per cycle
// to a single-ported memory, and routes in-order responses back to the requesting ports.
module port_request_sequencer #(
  parameter int WIDTH       = 8,
  parameter int RDATA_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       lane1_in,
  input  logic [WIDTH-1:0]       lane2_in,
  input  logic [WIDTH-1:0]       lane3_in,
  input  logic [1:0]             lane1_id,
  input  logic [1:0]             lane2_id,
  input  logic [1:0]             lane3_id,
  input  logic [1:0]             lane1_req_tag,
  input  logic [1:0]             lane2_req_tag,
  input  logic [1:0]             lane3_req_tag,
  input  logic                   lane1_valid,
  input  logic                   lane2_valid,
  input  logic                   lane3_valid,
  output logic                   ready,
  output logic [WIDTH-1:0]       mem_req_data,
  output logic                   mem_req_valid,
  input  logic [RDATA_WIDTH-1:0] mem_rsp_data,
  input  logic                   mem_rsp_valid,
  output logic [RDATA_WIDTH-1:0] port1_rsp_data,
  output logic [RDATA_WIDTH-1:0] port2_rsp_data,
  output logic [RDATA_WIDTH-1:0] port3_rsp_data,
  output logic [1:0]             port1_rsp_tag,
  output logic [1:0]             port2_rsp_tag,
  output logic [1:0]             port3_rsp_tag,
  output logic                   port1_rsp_valid,
  output logic                   port2_rsp_valid,
  output logic                   port3_rsp_valid,
  output logic                   rsp_error
);

  // Handshakes: a bundle transfers on a rising edge where ready=1 and lane1 is valid
  // with a nonzero ID; mem_req_valid and port*_rsp_valid are one-cycle strobes with
  // no back-pressure; mem_rsp_valid is a one-cycle strobe, responses in issue order.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic             lane_ok [3];
  logic [1:0]       prefix_n;
  logic             capture;

  logic [WIDTH-1:0] cap_data [3];
  logic [1:0]       cap_id   [3];
  logic [1:0]       cap_tag  [3];
  logic [1:0]       cap_count;
  logic [1:0]       issue_idx;

  logic [1:0]       q_id       [3];
  logic [1:0]       q_tag      [3];
  logic [1:0]       q_count;
  logic [1:0]       q_id_next  [3];
  logic [1:0]       q_tag_next [3];
  logic [1:0]       q_count_next;
  logic [1:0]       q_after_pop;

  logic             push;
  logic             pop;
  logic             rsp_drop;

  logic [RDATA_WIDTH-1:0] rsp_data_r  [3];
  logic [1:0]             rsp_tag_r   [3];
  logic                   rsp_valid_r [3];

  assign lane_ok[0] = lane1_valid && (lane1_id != 2'd0);
  assign lane_ok[1] = lane2_valid && (lane2_id != 2'd0);
  assign lane_ok[2] = lane3_valid && (lane3_id != 2'd0);

  // Lanes after the first invalid one are ignored even if they look valid.
  always_comb begin
    prefix_n = 2'd3;
    if (!lane_ok[0]) begin
      prefix_n = 2'd0;
    end else if (!lane_ok[1]) begin
      prefix_n = 2'd1;
    end else if (!lane_ok[2]) begin
      prefix_n = 2'd2;
    end
  end

  assign ready    = (state == IDLE) && !rst;
  assign capture  = ready && lane_ok[0];
  assign push     = (state == ISSUE);
  assign pop      = mem_rsp_valid && (q_count != 2'd0);
  assign rsp_drop = mem_rsp_valid && (q_count == 2'd0);

  assign mem_req_valid = push;
  assign mem_req_data  = push ? cap_data[issue_idx] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (capture) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (issue_idx == cap_count - 2'd1) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (q_count == 2'd0 || (pop && q_count == 2'd1)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        cap_data[i] <= '0;
        cap_id[i]   <= '0;
        cap_tag[i]  <= '0;
      end
      cap_count <= '0;
      issue_idx <= '0;
    end else begin
      if (capture) begin
        cap_data[0] <= lane1_in;
        cap_data[1] <= lane2_in;
        cap_data[2] <= lane3_in;
        cap_id[0]   <= lane1_id;
        cap_id[1]   <= lane2_id;
        cap_id[2]   <= lane3_id;
        cap_tag[0]  <= lane1_req_tag;
        cap_tag[1]  <= lane2_req_tag;
        cap_tag[2]  <= lane3_req_tag;
        cap_count   <= prefix_n;
        issue_idx   <= '0;
      end else if (push) begin
        issue_idx <= issue_idx + 2'd1;
      end
    end
  end

  // Tracking queue: head at index 0; a pop shifts down before a same-cycle push lands.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      q_id_next[i]  = q_id[i];
      q_tag_next[i] = q_tag[i];
    end
    if (pop) begin
      q_id_next[0]  = q_id[1];
      q_tag_next[0] = q_tag[1];
      q_id_next[1]  = q_id[2];
      q_tag_next[1] = q_tag[2];
      q_id_next[2]  = '0;
      q_tag_next[2] = '0;
    end
    q_after_pop = q_count - 2'(pop);
    for (int i = 0; i < 3; i++) begin
      if (push && q_after_pop == 2'(i)) begin
        q_id_next[i]  = cap_id[issue_idx];
        q_tag_next[i] = cap_tag[issue_idx];
      end
    end
    q_count_next = q_after_pop + 2'(push);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        q_id[i]  <= '0;
        q_tag[i] <= '0;
      end
      q_count <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        q_id[i]  <= q_id_next[i];
        q_tag[i] <= q_tag_next[i];
      end
      q_count <= q_count_next;
    end
  end

  // Response data and tag hold between pulses; only the addressed port updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        rsp_data_r[i]  <= '0;
        rsp_tag_r[i]   <= '0;
        rsp_valid_r[i] <= 1'b0;
      end
      rsp_error <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        rsp_valid_r[i] <= pop && (q_id[0] == 2'(i + 1));
        if (pop && (q_id[0] == 2'(i + 1))) begin
          rsp_data_r[i] <= mem_rsp_data;
          rsp_tag_r[i]  <= q_tag[0];
        end
      end
      if (rsp_drop) begin
        rsp_error <= 1'b1;
      end
    end
  end

  assign port1_rsp_data  = rsp_data_r[0];
  assign port2_rsp_data  = rsp_data_r[1];
  assign port3_rsp_data  = rsp_data_r[2];
  assign port1_rsp_tag   = rsp_tag_r[0];
  assign port2_rsp_tag   = rsp_tag_r[1];
  assign port3_rsp_tag   = rsp_tag_r[2];
  assign port1_rsp_valid = rsp_valid_r[0];
  assign port2_rsp_valid = rsp_valid_r[1];
  assign port3_rsp_valid = rsp_valid_r[2];

endmodule

// File: tb/tb_port_request_sequencer.sv
// Self-checking bench for port_request_sequencer: directed vector table, reset and
// error corner sequences, then randomized bundles against a transaction-level model.
module tb_port_request_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] lin  [3];
  logic [1:0] lid  [3];
  logic [1:0] ltag [3];
  logic       lval [3];
  logic       ready;
  logic [7:0] mem_req_data;
  logic       mem_req_valid;
  logic [7:0] mem_rsp_data;
  logic       mem_rsp_valid;
  logic [7:0] prd [3];
  logic [1:0] prt [3];
  logic       prv [3];
  logic       rsp_error;

  always #5 clk = ~clk;

  port_request_sequencer #(.WIDTH(8), .RDATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .lane1_in(lin[0]), .lane2_in(lin[1]), .lane3_in(lin[2]),
    .lane1_id(lid[0]), .lane2_id(lid[1]), .lane3_id(lid[2]),
    .lane1_req_tag(ltag[0]), .lane2_req_tag(ltag[1]), .lane3_req_tag(ltag[2]),
    .lane1_valid(lval[0]), .lane2_valid(lval[1]), .lane3_valid(lval[2]),
    .ready(ready),
    .mem_req_data(mem_req_data), .mem_req_valid(mem_req_valid),
    .mem_rsp_data(mem_rsp_data), .mem_rsp_valid(mem_rsp_valid),
    .port1_rsp_data(prd[0]), .port2_rsp_data(prd[1]), .port3_rsp_data(prd[2]),
    .port1_rsp_tag(prt[0]), .port2_rsp_tag(prt[1]), .port3_rsp_tag(prt[2]),
    .port1_rsp_valid(prv[0]), .port2_rsp_valid(prv[1]), .port3_rsp_valid(prv[2]),
    .rsp_error(rsp_error)
  );

  int checks;
  int failures;

  // Reference model: outstanding {id,tag} queue plus expected port-side state.
  logic [3:0] exp_q[$];
  logic [7:0] last_data [3];
  logic [1:0] last_tag  [3];
  logic       cur_v, nxt_v;
  logic [1:0] cur_port, nxt_port;
  logic [7:0] cur_data, nxt_data;
  logic [1:0] cur_tag, nxt_tag;
  logic       err_m, nxt_err;

  typedef struct {
    logic [2:0]  v;
    logic [5:0]  ids;
    logic [5:0]  tags;
    logic [23:0] data;
    logic [23:0] rdata;
    int          gap_max;
    int          exp_n;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int prefix_n(input logic [2:0] v, input logic [5:0] ids);
    int n;
    bit ok;
    n = 0;
    ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ok = ok && v[k] && (ids[2*k +: 2] != 2'd0);
      if (ok) n++;
    end
    return n;
  endfunction

  task automatic cyc();
    @(negedge clk);
    cur_v = nxt_v; cur_port = nxt_port; cur_data = nxt_data; cur_tag = nxt_tag;
    nxt_v = 1'b0;
    if (nxt_err) err_m = 1'b1;
    nxt_err = 1'b0;
    if (cur_v) begin
      last_data[cur_port - 1] = cur_data;
      last_tag[cur_port - 1]  = cur_tag;
    end
  endtask

  task automatic check_common();
    for (int p = 0; p < 3; p++) begin
      chk($sformatf("port%0d_rsp_valid", p + 1), 32'(prv[p]), 32'(cur_v && (cur_port == p + 1)));
      chk($sformatf("port%0d_rsp_data", p + 1), 32'(prd[p]), 32'(last_data[p]));
      chk($sformatf("port%0d_rsp_tag", p + 1), 32'(prt[p]), 32'(last_tag[p]));
    end
    chk("rsp_error", 32'(rsp_error), 32'(err_m));
  endtask

  task automatic drive_rsp(input logic [7:0] d);
    logic [3:0] e;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = d;
    if (exp_q.size() == 0) begin
      nxt_err = 1'b1;
    end else begin
      e = exp_q.pop_front();
      nxt_v = 1'b1; nxt_port = e[3:2]; nxt_tag = e[1:0]; nxt_data = d;
    end
  endtask

  task automatic clear_lanes();
    for (int k = 0; k < 3; k++) begin
      lin[k] = '0; lid[k] = '0; ltag[k] = '0; lval[k] = 1'b0;
    end
  endtask

  task automatic junk_lanes();
    for (int k = 0; k < 3; k++) begin
      lin[k]  = 8'($urandom);
      lid[k]  = 2'($urandom_range(0, 3));
      ltag[k] = 2'($urandom_range(0, 3));
      lval[k] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b1; clear_lanes(); mem_rsp_valid = 1'b0;
    #1;
    check_common();
    chk("ready_in_reset", 32'(ready), 32'd0);
    exp_q.delete();
    err_m = 1'b0; nxt_err = 1'b0; nxt_v = 1'b0;
    for (int p = 0; p < 3; p++) begin
      last_data[p] = '0; last_tag[p] = '0;
    end
    cyc();
    #1;
    check_common();
    chk("ready_in_reset", 32'(ready), 32'd0);
    chk("mem_req_valid_reset", 32'(mem_req_valid), 32'd0);
    chk("mem_req_data_reset", 32'(mem_req_data), 32'd0);
    cyc();
    rst = 1'b0;
    #1;
    check_common();
    chk("ready_after_reset", 32'(ready), 32'd1);
  endtask

  task automatic idle_cycle(input bit rsp);
    cyc();
    junk_lanes();
    if (lval[0]) lid[0] = 2'd0;
    mem_rsp_valid = 1'b0;
    if (rsp) drive_rsp(8'($urandom));
    #1;
    check_common();
    chk("ready_idle", 32'(ready), 32'd1);
    chk("mem_req_idle", 32'(mem_req_valid), 32'd0);
  endtask

  task automatic run_txn(input logic [2:0] v, input logic [5:0] ids, input logic [5:0] tags,
                         input logic [23:0] data, input logic [23:0] rdata,
                         input int gap_max, output int seen);
    int n, last, j, prev;
    int rs [3];
    seen = 0;
    cyc();
    for (int k = 0; k < 3; k++) begin
      lval[k] = v[k]; lid[k] = ids[2*k +: 2]; ltag[k] = tags[2*k +: 2]; lin[k] = data[8*k +: 8];
    end
    mem_rsp_valid = 1'b0;
    #1;
    check_common();
    chk("ready_at_capture", 32'(ready), 32'd1);
    n = prefix_n(v, ids);
    if (n == 0) return;
    prev = 1;
    for (int k = 0; k < n; k++) begin
      rs[k] = ((prev + 1) > (k + 2) ? (prev + 1) : (k + 2)) + int'($urandom_range(0, gap_max));
      prev = rs[k];
    end
    last = rs[n-1];
    j = 0;
    for (int c = 1; c <= last; c++) begin
      cyc();
      junk_lanes();
      mem_rsp_valid = 1'b0;
      if (j < n && rs[j] == c) begin
        drive_rsp(rdata[8*j +: 8]);
        j++;
      end
      if (c <= n) exp_q.push_back({ids[2*(c-1) +: 2], tags[2*(c-1) +: 2]});
      #1;
      check_common();
      chk("ready_busy", 32'(ready), 32'd0);
      if (c <= n) begin
        chk("mem_req_valid", 32'(mem_req_valid), 32'd1);
        chk("mem_req_data", 32'(mem_req_data), 32'(data[8*(c-1) +: 8]));
      end else begin
        chk("mem_req_extra", 32'(mem_req_valid), 32'd0);
      end
      seen += int'(mem_req_valid);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    logic [2:0]  rv;
    logic [5:0]  rids, rtags;
    logic [23:0] rdat, rrsp;

    checks = 0; failures = 0;
    rst = 1'b1; clear_lanes();
    mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    for (int p = 0; p < 3; p++) begin
      last_data[p] = '0; last_tag[p] = '0;
    end
    cur_v = 0; nxt_v = 0; cur_port = 0; nxt_port = 0; cur_data = 0; nxt_data = 0;
    cur_tag = 0; nxt_tag = 0; err_m = 0; nxt_err = 0;

    vecs[0] = '{3'b111, {2'd3, 2'd2, 2'd1}, {2'b11, 2'b10, 2'b01}, 24'hC3B2A1, 24'h332211, 0, 3};
    vecs[1] = '{3'b101, {2'd3, 2'd2, 2'd1}, {2'b11, 2'b10, 2'b01}, 24'hC3B2A1, 24'h332211, 1, 1};
    vecs[2] = '{3'b001, {2'd0, 2'd0, 2'd3}, {2'b00, 2'b00, 2'b00}, 24'h00005E, 24'h00005A, 0, 1};
    vecs[3] = '{3'b111, {2'd1, 2'd0, 2'd2}, {2'b01, 2'b10, 2'b11}, 24'h445566, 24'h778899, 1, 1};
    vecs[4] = '{3'b011, {2'd0, 2'd1, 2'd2}, {2'b00, 2'b11, 2'b10}, 24'h0012F0, 24'h00AB3C, 2, 2};
    vecs[5] = '{3'b111, {2'd1, 2'd1, 2'd1}, {2'b10, 2'b01, 2'b00}, 24'h0A0B0C, 24'hE1E2E3, 2, 3};

    repeat (2) @(posedge clk);
    do_reset();
    idle_cycle(0);
    idle_cycle(0);

    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i].v, vecs[i].ids, vecs[i].tags, vecs[i].data, vecs[i].rdata,
              vecs[i].gap_max, seen);
      chk($sformatf("issue_count_vec%0d", i), 32'(seen), 32'(vecs[i].exp_n));
      idle_cycle(0);
    end

    // Stray response while idle: sticky error survives a later transaction.
    idle_cycle(1);
    idle_cycle(0);
    run_txn(3'b011, {2'd0, 2'd3, 2'd2}, 6'b000110, 24'h001122, 24'h003344, 1, seen);
    idle_cycle(0);
    do_reset();

    // Reset in the second issue cycle of a three-lane bundle.
    cyc();
    for (int k = 0; k < 3; k++) begin
      lval[k] = 1'b1; lid[k] = 2'(k + 1); ltag[k] = 2'(k + 1);
    end
    lin[0] = 8'hA1; lin[1] = 8'hB2; lin[2] = 8'hC3;
    #1;
    check_common();
    chk("ready_mid_capture", 32'(ready), 32'd1);
    cyc();
    junk_lanes();
    #1;
    check_common();
    chk("mid_mem_req_valid", 32'(mem_req_valid), 32'd1);
    chk("mid_mem_req_data", 32'(mem_req_data), 32'h0000_00A1);
    do_reset();
    idle_cycle(0);
    idle_cycle(0);
    idle_cycle(1);
    idle_cycle(0);
    do_reset();

    for (int t = 0; t < 40; t++) begin
      rv    = 3'($urandom_range(0, 7)) | 3'b001;
      rids  = {2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(1, 3))};
      rtags = 6'($urandom);
      rdat  = 24'($urandom);
      rrsp  = 24'($urandom);
      run_txn(rv, rids, rtags, rdat, rrsp, 2, seen);
      chk("rand_issue_count", 32'(seen), 32'(prefix_n(rv, rids)));
      if ($urandom_range(0, 1) == 1) idle_cycle(0);
    end
    idle_cycle(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/port_request_sequencer.md
Name: port_request_sequencer

Overview:
- Sits directly downstream of the three-lane validity filter.
- Captures one compacted request bundle per transaction: up to 3 lanes, each with payload, port ID (1..3, 0 = invalid) and 2-bit request tag.
- Issues the captured lanes one per cycle to the single-ported memory core.
- Routes each in-order memory response back to the originating port's response outputs, carrying that port's tag.

Parameters:
- WIDTH, 8, request payload width (address/command word forwarded unchanged to memory).
- RDATA_WIDTH, 8, memory response data width.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- lane1_in / lane2_in / lane3_in  input  WIDTH  compacted request payloads.
- lane1_id / lane2_id / lane3_id  input  2  originating port ID; 0 = invalid.
- lane1_req_tag / lane2_req_tag / lane3_req_tag  input  2  request tags.
- lane1_valid / lane2_valid / lane3_valid  input  1  lane valid.
- ready  output  1  high when a bundle can be captured this cycle.
- mem_req_data  output  WIDTH  payload issued to memory.
- mem_req_valid  output  1  one-cycle issue strobe per lane.
- mem_rsp_data  input  RDATA_WIDTH  memory response data.
- mem_rsp_valid  input  1  response strobe; responses return in issue order.
- port1_rsp_data / port2_rsp_data / port3_rsp_data  output  RDATA_WIDTH  routed response data.
- port1_rsp_tag / port2_rsp_tag / port3_rsp_tag  output  2  tag of the request being answered.
- port1_rsp_valid / port2_rsp_valid / port3_rsp_valid  output  1  one-cycle response pulse.
- rsp_error  output  1  sticky: response arrived with nothing outstanding.

Behaviour:
- Reset values:
  - ready=0 during reset, then 1 in the first cycle after rst deasserts.
  - All other outputs 0: mem_req_*, port*_rsp_*, rsp_error.
  - FSM in IDLE; capture count and tracking queue cleared.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - ready=1.
  - On ready & lane1_valid & lane1_id!=0: register all lanes and compute the valid-prefix count N:
    - lane k counts only if lanes 1..k are all valid with nonzero ID;
    - lanes after the first invalid one are ignored.
  - Go to ISSUE. ready=0 from the next cycle.
  - lane1_valid=0 (or lane1_id=0): stay in IDLE, nothing captured.
- ISSUE:
  - For each of the cycles 1..N after capture, issue lane k in order:
    - mem_req_valid=1, mem_req_data=lane k payload;
    - push {id, tag} of lane k into a 3-entry in-order tracking queue.
  - After lane N is issued, go to DRAIN. No back-pressure from memory.
- DRAIN and ISSUE, response handling:
  - Each mem_rsp_valid pops the queue head.
  - On the next cycle, assert port<id>_rsp_valid=1 with port<id>_rsp_data=mem_rsp_data and port<id>_rsp_tag=popped tag. Response latency is 1 register.
  - Other ports' rsp_valid=0. rsp_data/rsp_tag hold their last values when rsp_valid=0.
  - Response and issue in the same cycle: pop and push both occur; occupancy is unchanged.
- DRAIN exit: when occupancy reaches 0 (last pop), go to IDLE; ready=1 the following cycle.
- mem_rsp_valid with an empty queue: response dropped, rsp_error set to 1 until rst.
- One bundle in flight max, so the queue cannot overflow; a push to a full queue cannot occur.
- Reset mid-transaction:
  - All state cleared and outstanding responses discarded.
  - Memory responses arriving after reset with an empty queue set rsp_error. Integration must reset the memory core together with this block.

Test Plan:
- 3 valid lanes, IDs 1,2,3, tags 2'b01, 2'b10, 2'b11, payloads 8'hA1, 8'hB2, 8'hC3, captured at cycle 0:
  - mem_req_valid in cycles 1,2,3 with A1, B2, C3.
  - Responses 8'h11, 8'h22, 8'h33 at cycles 2,3,4 -> port1_rsp (11, tag 01) cycle 3, port2_rsp (22, tag 10) cycle 4, port3_rsp (33, tag 11) cycle 5.
  - ready=1 from cycle 5.
- Lanes 1,3 valid, lane2 invalid -> only lane1 issued (N=1); lane3 is never issued.
- Single lane, ID 3, tag 2'b00 -> response 8'h5A returns on port3_rsp_data with tag 00; port1/port2_rsp_valid stay 0.
- mem_rsp_valid pulse while in IDLE -> rsp_error=1 next cycle; it stays 1 until rst.
- rst asserted in cycle 2 of a 3-lane issue:
  - All outputs 0 next cycle.
  - No further mem_req_valid.
  - ready=1 the cycle after rst deasserts.
- lane1_valid held high continuously -> new bundle captured only when ready=1; there is exactly one capture per transaction.
